// File: rtl/divint_pkg.sv
// Shared types and helpers for the iterative integer divider.
package divint_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // One extra bit so the counter can represent WIDTH itself without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/divint_step.sv
// One restoring shift-subtract iteration on magnitudes: shift in the next dividend bit,
// trial-subtract the divisor over a WIDTH+1-bit accumulator, insert the quotient bit.
module divint_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] dq_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] dq_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           qbit;

    // The partial remainder stays below the divisor, so the difference's top bit is
    // set exactly when the trial subtraction borrows.
    always_comb begin
        shifted = {rem_i, dq_i[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_i};
        qbit    = ~diff[WIDTH];
        rem_o   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        dq_o    = {dq_i[WIDTH-2:0], qbit};
    end

endmodule

// File: rtl/divint.sv
// Iterative signed/unsigned integer divider, one quotient bit per cycle, valid/ready on both sides.
// Latency WIDTH cycles from accept (1 cycle for divide-by-zero); result held until out_ready.
module divint
    import divint_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] rem,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] racc_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             zdiv_q;
    logic             ovf_pend_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] rem_q;
    logic             dbz_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic             a_neg_d;
    logic             b_neg_d;
    logic [WIDTH-1:0] a_mag_d;
    logic [WIDTH-1:0] b_mag_d;
    logic             ovf_d;
    logic [WIDTH-1:0] racc_d;
    logic [WIDTH-1:0] dq_d;

    always_comb begin
        a_neg_d = is_signed & a[WIDTH-1];
        b_neg_d = is_signed & b[WIDTH-1];
        a_mag_d = a_neg_d ? -a : a;
        b_mag_d = b_neg_d ? -b : b;
        ovf_d   = is_signed && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}});
    end

    divint_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (racc_q),
        .dq_i  (dq_q),
        .dvs_i (dvs_q),
        .rem_o (racc_d),
        .dq_o  (dq_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            racc_q      <= '0;
            dq_q        <= '0;
            dvs_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            zdiv_q      <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quotient_q  <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            zdiv_q      <= 1'b0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        neg_q_q    <= a_neg_d ^ b_neg_d;
                        neg_r_q    <= a_neg_d;
                        dvs_q      <= b_mag_d;
                        racc_q     <= '0;
                        cnt_q      <= '0;
                        zdiv_q     <= (b == '0);
                        // A zero divisor keeps the raw dividend, which becomes the remainder.
                        dq_q       <= (b == '0) ? a : a_mag_d;
                        ovf_pend_q <= ovf_d;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (zdiv_q) begin
                        quotient_q  <= '1;
                        rem_q       <= dq_q;
                        dbz_q       <= 1'b1;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        racc_q <= racc_d;
                        dq_q   <= dq_d;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            quotient_q  <= neg_q_q ? -dq_d : dq_d;
                            rem_q       <= neg_r_q ? -racc_d : racc_d;
                            dbz_q       <= 1'b0;
                            ovf_q       <= ovf_pend_q;
                            out_valid_q <= 1'b1;
                            cnt_q       <= '0;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign rem       = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: doc/divint.md
DIVINT -- requirements
Module: divint

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal range 2..64).
REQ-002 SHALL have input clk, 1 bit, rising-edge clock.
REQ-003 SHALL have input rst, 1 bit, reset: asynchronous, active-high.
REQ-004 SHALL have input in_valid, 1 bit, operands offered.
REQ-005 SHALL have output in_ready, 1 bit, block can accept operands.
REQ-006 SHALL have input is_signed, 1 bit, 1 = two's-complement operation, 0 = unsigned; sampled with the operands.
REQ-007 SHALL have input a, WIDTH bits, dividend.
REQ-008 SHALL have input b, WIDTH bits, divisor.
REQ-009 SHALL have input abort, 1 bit, synchronous flush of any operation in flight.
REQ-010 SHALL have output out_valid, 1 bit, result available.
REQ-011 SHALL have input out_ready, 1 bit, consumer accepts the result.
REQ-012 SHALL have output quotient, WIDTH bits, result quotient.
REQ-013 SHALL have output rem, WIDTH bits, result remainder.
REQ-014 SHALL have output dbz, 1 bit, divide-by-zero flag, qualified by out_valid.
REQ-015 SHALL have output ovf, 1 bit, signed-overflow flag, qualified by out_valid.

Function
REQ-016 SHALL implement states IDLE, CALC and DONE; in_ready = 1 only in IDLE.
REQ-017 SHALL accept an operation on a rising edge where in_valid and in_ready are both 1, capturing is_signed, |a|, |b|, sign(a) and sign(a) XOR sign(b).
REQ-018 SHALL, on accept with b != 0, enter CALC, produce one quotient bit per cycle by restoring shift-subtract on magnitudes over a WIDTH+1-bit accumulator, and run exactly WIDTH iterations.
REQ-019 SHALL, on the final iteration edge, apply sign fixup: quotient negated when the sign-XOR bit is set, remainder negated when the dividend was negative (truncating division; the remainder takes the dividend's sign); then enter DONE with out_valid = 1.
REQ-020 SHALL raise out_valid exactly WIDTH cycles after the accept edge for b != 0.
REQ-021 SHALL, on accept with b = 0, skip CALC, enter DONE one cycle after accept with quotient = all ones, rem = a, dbz = 1, ovf = 0.
REQ-022 SHALL, for is_signed = 1, a = most-negative value and b = all ones, produce quotient = a, rem = 0, ovf = 1, dbz = 0, with normal WIDTH-cycle latency.
REQ-023 SHALL hold out_valid, quotient, rem, dbz and ovf stable in DONE until out_ready = 1, then return to IDLE on that edge; out_valid SHALL fall on the next cycle.
REQ-024 SHALL treat is_signed = 0 operands as pure unsigned; no sign fixup, ovf always 0.
REQ-025 SHALL, when abort = 1 on an edge, return to IDLE from any state, clear out_valid, dbz and ovf, and discard the operation; abort SHALL take priority over accept and over the out_valid/out_ready completion.
REQ-026 SHALL ignore in_valid outside IDLE; operands SHALL NOT be re-sampled during CALC or DONE.
REQ-027 SHALL size the iteration counter as $clog2(WIDTH)+1 bits and compare it at full width without truncation.

Reset
REQ-028 SHALL, while rst = 1, force state IDLE, in_ready = 1 (once rst is released), out_valid = 0, quotient = 0, rem = 0, dbz = 0, ovf = 0, counter = 0.
REQ-029 SHALL, when rst is asserted during CALC or DONE, discard the operation with no out_valid pulse after release.

Structure
REQ-030 SHALL place the state enumeration and the iteration-counter width function in shared package divint_pkg.
REQ-031 SHALL isolate the combinational single-iteration step (accumulator compare/subtract/shift, quotient bit insert) in sub-module divint_step; the control FSM, magnitude conversion and sign fixup SHALL remain in divint.

Verification (WIDTH = 8)
REQ-032 SHALL test unsigned 100/7: accept, then out_valid exactly 8 cycles later with quotient 14, rem 2, dbz 0, ovf 0.
REQ-033 SHALL test signed 0xF9/0x02 (-7/2): quotient 0xFD, rem 0xFF; signed 0x07/0xFE (7/-2): quotient 0xFD, rem 0x01.
REQ-034 SHALL test signed 0x80/0xFF: quotient 0x80, rem 0x00, ovf 1; and unsigned 0x2A/0x00: out_valid 1 cycle after accept, quotient 0xFF, rem 0x2A, dbz 1.
REQ-035 SHALL test back-pressure: out_ready held 0 for 5 cycles; results stay stable and in_ready = 0 throughout; a new in_valid is ignored until the result is taken.
REQ-036 SHALL test abort at iteration 3 and rst at iteration 5: the block returns to IDLE, no out_valid follows, and the next operation (200/10 -> 20 rem 0) is correct.
